// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared FSM state encodings and oversampling constant for the UART.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int OVERSAMPLE = 16;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd4
    } tx_state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// ============================================================================
// Module : uart_sync_fifo
// Brief  : Synchronous fall-through FIFO, depth 2^FIFO_W; head reads 0 when empty.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_sync_fifo #(
    parameter int DBIT   = 8,
    parameter int FIFO_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr,
    input  logic            rd,
    input  logic [DBIT-1:0] w_data,
    output logic [DBIT-1:0] r_data,
    output logic            empty,
    output logic            full
);

    localparam int DEPTH = 1 << FIFO_W;
    localparam logic [FIFO_W:0] PTR_ONE = {{FIFO_W{1'b0}}, 1'b1};

    logic [DBIT-1:0] mem [DEPTH];
    logic [FIFO_W:0] wr_ptr;
    logic [FIFO_W:0] rd_ptr;
    logic            do_wr;
    logic            do_rd;

    // Extra pointer MSB separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_W] != rd_ptr[FIFO_W]) &&
                   (wr_ptr[FIFO_W-1:0] == rd_ptr[FIFO_W-1:0]);

    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[FIFO_W-1:0]] <= w_data;
    end

    assign r_data = empty ? '0 : mem[rd_ptr[FIFO_W-1:0]];

endmodule

`default_nettype wire

// File: rtl/uart_fifo_core.sv
// ============================================================================
// Module : uart_fifo_core
// Brief  : Full-duplex UART with 16x baud tick, RX/TX FSMs and FIFOs.
//          Optional parity bit enabled by defining UART_PARITY_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 19200,
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int FIFO_W     = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic            tx,
    input  logic [DBIT-1:0] w_data,
    input  logic            wr_uart,
    output logic [DBIT-1:0] r_data,
    input  logic            rd_uart,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            tx_empty,
    output logic            tx_full,
    output logic            frame_err,
    output logic            parity_err,
    output logic            overrun,
    input  logic            clr_err
);

    localparam int DIV = CLK_HZ / (OVERSAMPLE * BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [4:0] HALF_LAST = 5'd6;
    localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] SB_LAST   = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

    logic [CW-1:0]   baud_cnt;
    logic            tick;
    logic [1:0]      rx_sync;
    logic            rx_in;

    rx_state_t       rx_state, rx_state_n;
    logic [4:0]      rx_s, rx_s_n;
    logic [2:0]      rx_n, rx_n_n;
    logic [DBIT-1:0] rx_b, rx_b_n;
    logic            rx_push, ferr_set, ovr_set;

    tx_state_t       tx_state, tx_state_n;
    logic [4:0]      tx_s, tx_s_n;
    logic [2:0]      tx_n, tx_n_n;
    logic [DBIT-1:0] tx_b, tx_b_n;
    logic [DBIT-1:0] tx_head;
    logic            tx_pop;

    assign tick = (baud_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
            rx_sync  <= 2'b11;
        end else begin
            baud_cnt <= tick ? '0 : baud_cnt + CW'(1);
            rx_sync  <= {rx_sync[0], rx};
        end
    end

    assign rx_in = rx_sync[1];

`ifdef UART_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic perr_set;
    logic tx_par, tx_par_n;
`else
    logic cfg_unused;
    assign cfg_unused = (PARITY_ODD != 0);
    assign parity_err = 1'b0;
`endif

    // ---------------- RX FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_s     <= '0;
            rx_n     <= '0;
            rx_b     <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_s     <= rx_s_n;
            rx_n     <= rx_n_n;
            rx_b     <= rx_b_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_s_n     = rx_s;
        rx_n_n     = rx_n;
        rx_b_n     = rx_b;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
`ifdef UART_PARITY_EN
        perr_set   = 1'b0;
`endif
        case (rx_state)
            RX_IDLE: if (!rx_in) begin
                rx_state_n = RX_START;
                rx_s_n     = '0;
            end
            // A start bit that has gone high by mid-bit is treated as noise.
            RX_START: if (tick) begin
                if (rx_s == HALF_LAST) begin
                    rx_s_n     = '0;
                    rx_n_n     = '0;
                    rx_state_n = rx_in ? RX_IDLE : RX_DATA;
                end else rx_s_n = rx_s + 5'd1;
            end
            RX_DATA: if (tick) begin
                if (rx_s == BIT_LAST) begin
                    rx_s_n = '0;
                    rx_b_n = {rx_in, rx_b[DBIT-1:1]};
                    if (rx_n == N_LAST)
`ifdef UART_PARITY_EN
                        rx_state_n = RX_PARITY;
`else
                        rx_state_n = RX_STOP;
`endif
                    else rx_n_n = rx_n + 3'd1;
                end else rx_s_n = rx_s + 5'd1;
            end
`ifdef UART_PARITY_EN
            RX_PARITY: if (tick) begin
                if (rx_s == BIT_LAST) begin
                    rx_s_n     = '0;
                    perr_set   = (rx_in != ((^rx_b) ^ PAR_ODD));
                    rx_state_n = RX_STOP;
                end else rx_s_n = rx_s + 5'd1;
            end
`endif
            RX_STOP: if (tick) begin
                if (rx_s == SB_LAST) begin
                    rx_s_n     = '0;
                    rx_push    = 1'b1;
                    ferr_set   = !rx_in;
                    rx_state_n = RX_IDLE;
                end else rx_s_n = rx_s + 5'd1;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // A simultaneous pop frees a slot, so only an unaccepted push overruns.
    assign ovr_set = rx_push && rx_full && !rd_uart;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ferr_set)     frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (ovr_set)      overrun   <= 1'b1;
            else if (clr_err) overrun   <= 1'b0;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset)         parity_err <= 1'b0;
        else if (perr_set) parity_err <= 1'b1;
        else if (clr_err)  parity_err <= 1'b0;
    end
`endif

    // ---------------- TX FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_b     <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_s     <= tx_s_n;
            tx_n     <= tx_n_n;
            tx_b     <= tx_b_n;
`ifdef UART_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_s_n     = tx_s;
        tx_n_n     = tx_n;
        tx_b_n     = tx_b;
        tx_pop     = 1'b0;
        tx         = 1'b1;
`ifdef UART_PARITY_EN
        tx_par_n   = tx_par;
`endif
        case (tx_state)
            TX_IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_b_n     = tx_head;
                tx_s_n     = '0;
                tx_state_n = TX_START;
`ifdef UART_PARITY_EN
                tx_par_n   = (^tx_head) ^ PAR_ODD;
`endif
            end
            TX_START: begin
                tx = 1'b0;
                if (tick) begin
                    if (tx_s == BIT_LAST) begin
                        tx_s_n     = '0;
                        tx_n_n     = '0;
                        tx_state_n = TX_DATA;
                    end else tx_s_n = tx_s + 5'd1;
                end
            end
            TX_DATA: begin
                tx = tx_b[0];
                if (tick) begin
                    if (tx_s == BIT_LAST) begin
                        tx_s_n = '0;
                        tx_b_n = tx_b >> 1;
                        if (tx_n == N_LAST)
`ifdef UART_PARITY_EN
                            tx_state_n = TX_PARITY;
`else
                            tx_state_n = TX_STOP;
`endif
                        else tx_n_n = tx_n + 3'd1;
                    end else tx_s_n = tx_s + 5'd1;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                tx = tx_par;
                if (tick) begin
                    if (tx_s == BIT_LAST) begin
                        tx_s_n     = '0;
                        tx_state_n = TX_STOP;
                    end else tx_s_n = tx_s + 5'd1;
                end
            end
`endif
            // Reload directly from STOP so back-to-back frames have no gap.
            TX_STOP: if (tick) begin
                if (tx_s == SB_LAST) begin
                    tx_s_n = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_b_n     = tx_head;
                        tx_state_n = TX_START;
`ifdef UART_PARITY_EN
                        tx_par_n   = (^tx_head) ^ PAR_ODD;
`endif
                    end else tx_state_n = TX_IDLE;
                end else tx_s_n = tx_s + 5'd1;
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    uart_sync_fifo #(.DBIT(DBIT), .FIFO_W(FIFO_W)) u_rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (rx_push),
        .rd     (rd_uart),
        .w_data (rx_b),
        .r_data (r_data),
        .empty  (rx_empty),
        .full   (rx_full)
    );

    uart_sync_fifo #(.DBIT(DBIT), .FIFO_W(FIFO_W)) u_tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr_uart),
        .rd     (tx_pop),
        .w_data (w_data),
        .r_data (tx_head),
        .empty  (tx_empty),
        .full   (tx_full)
    );

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo_core.sv
// ============================================================================
// Module : tb_uart_fifo_core
// Brief  : Scoreboard bench for uart_fifo_core (fast clock, divider of 4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_fifo_core;

    localparam int BAUD       = 19200;
    localparam int DIV        = 4;
    localparam int CLK_HZ     = 16 * BAUD * DIV;
    localparam int DBIT       = 8;
    localparam int SB_TICK    = 16;
    localparam int FIFO_W     = 4;
    localparam int PARITY_ODD = 0;
    localparam int BIT_CYC    = 16 * DIV;
`ifdef UART_PARITY_EN
    localparam int PBIT = 1;
`else
    localparam int PBIT = 0;
`endif
    localparam int FRAME_CYC  = (1 + DBIT + PBIT) * BIT_CYC + SB_TICK * DIV;

    logic            clk = 1'b0;
    logic            reset, rx, tx, wr_uart, rd_uart, clr_err;
    logic [DBIT-1:0] w_data, r_data;
    logic            rx_empty, rx_full, tx_empty, tx_full;
    logic            frame_err, parity_err, overrun;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];

    always #5 clk = ~clk;

    uart_fifo_core #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DBIT(DBIT), .SB_TICK(SB_TICK),
        .FIFO_W(FIFO_W), .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx), .w_data(w_data),
        .wr_uart(wr_uart), .r_data(r_data), .rd_uart(rd_uart),
        .rx_empty(rx_empty), .rx_full(rx_full), .tx_empty(tx_empty),
        .tx_full(tx_full), .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun), .clr_err(clr_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_write(input logic [7:0] b);
        w_data  = b;
        wr_uart = 1'b1;
        tx_exp_q.push_back(b);
        step();
        wr_uart = 1'b0;
    endtask

    // Decodes one frame on tx, sampling mid-bit from the falling start edge.
    task automatic tx_capture(output int waited);
        logic [7:0] got;
        logic [7:0] exp;
        got    = '0;
        waited = 0;
        while (tx !== 1'b0 && waited < 4 * FRAME_CYC) begin
            step();
            waited++;
        end
        if (tx !== 1'b0) begin
            check("tx_start_timeout", 32'd0, 32'd1);
            return;
        end
        repeat (8 * DIV) step();
        check("tx_start_bit", tx, 32'd0);
        for (int i = 0; i < DBIT; i++) begin
            repeat (BIT_CYC) step();
            got[i] = tx;
        end
`ifdef UART_PARITY_EN
        repeat (BIT_CYC) step();
        check("tx_parity_bit", tx, (^got) ^ PARITY_ODD[0]);
`endif
        repeat (BIT_CYC) step();
        check("tx_stop_bit", tx, 32'd1);
        if (tx_exp_q.size() == 0) begin
            check("tx_unexpected_frame", 32'd0, 32'd1);
            return;
        end
        exp = tx_exp_q.pop_front();
        check("tx_byte", got, exp);
    endtask

    // A stop_val of 0 is held past the receiver's sample point then released,
    // so the tail of the bad stop bit reads as a rejected glitch.
    task automatic rx_send(input logic [7:0] b, input logic stop_val, input logic par_flip);
        rx = 1'b0;
        repeat (BIT_CYC) step();
        for (int i = 0; i < DBIT; i++) begin
            rx = b[i];
            repeat (BIT_CYC) step();
        end
`ifdef UART_PARITY_EN
        rx = (^b) ^ PARITY_ODD[0] ^ par_flip;
        repeat (BIT_CYC) step();
`else
        if (par_flip) rx = 1'b1;
`endif
        if (stop_val) begin
            rx = 1'b1;
            repeat (BIT_CYC) step();
        end else begin
            rx = 1'b0;
            repeat (10 * DIV) step();
            rx = 1'b1;
            repeat (6 * DIV) step();
        end
        rx = 1'b1;
    endtask

    task automatic rx_pop_check(input string tag);
        logic [7:0] exp;
        check({tag, "_not_empty"}, rx_empty, 32'd0);
        if (rx_exp_q.size() == 0) begin
            check({tag, "_no_expect"}, 32'd0, 32'd1);
            return;
        end
        exp = rx_exp_q.pop_front();
        check({tag, "_data"}, r_data, exp);
        rd_uart = 1'b1;
        step();
        rd_uart = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    initial begin
        int gap;
        reset   = 1'b1;
        rx      = 1'b1;
        wr_uart = 1'b0;
        rd_uart = 1'b0;
        clr_err = 1'b0;
        w_data  = '0;
        repeat (3) step();
        reset = 1'b0;

        check("rst_tx", tx, 32'd1);
        check("rst_rx_empty", rx_empty, 32'd1);
        check("rst_tx_empty", tx_empty, 32'd1);
        check("rst_rx_full", rx_full, 32'd0);
        check("rst_tx_full", tx_full, 32'd0);
        check("rst_r_data", r_data, 32'd0);
        check("rst_errs", {frame_err, parity_err, overrun}, 32'd0);

        // Single TX frame with latency checks
        tx_write(8'hA5);
        check("tx_empty_fall_n1", tx_empty, 32'd0);
        check("tx_idle_n1", tx, 32'd1);
        step();
        check("tx_low_n2", tx, 32'd0);
        tx_capture(gap);
        check("tx_empty_after", tx_empty, 32'd1);

        // Back-to-back TX frames
        tx_write(8'h00);
        tx_write(8'hFF);
        tx_write(8'h5A);
        tx_capture(gap);
        tx_capture(gap);
        check("tx_b2b_gap1", (gap <= 10 * DIV), 32'd1);
        tx_capture(gap);
        check("tx_b2b_gap2", (gap <= 10 * DIV), 32'd1);

        // RX of a clean byte
        rx_exp_q.push_back(8'h3C);
        rx_send(8'h3C, 1'b1, 1'b0);
        repeat (2) step();
        rx_pop_check("rx_3c");
        check("rx_3c_frame_err", frame_err, 32'd0);
        check("rx_3c_empty_after", rx_empty, 32'd1);

        // Glitch rejection, then a normal byte
        rx = 1'b0;
        repeat (3 * DIV) step();
        rx = 1'b1;
        repeat (FRAME_CYC) step();
        check("glitch_nothing_pushed", rx_empty, 32'd1);
        rx_exp_q.push_back(8'hC3);
        rx_send(8'hC3, 1'b1, 1'b0);
        repeat (2) step();
        rx_pop_check("rx_after_glitch");

        // Frame error: byte still pushed, flag sticky until cleared
        rx_exp_q.push_back(8'h81);
        rx_send(8'h81, 1'b0, 1'b0);
        repeat (FRAME_CYC) step();
        check("frame_err_set", frame_err, 32'd1);
        rx_pop_check("rx_ferr");
        check("ferr_no_extra_byte", rx_empty, 32'd1);
        pulse_clr();
        check("frame_err_clr", frame_err, 32'd0);

`ifdef UART_PARITY_EN
        rx_exp_q.push_back(8'h96);
        rx_send(8'h96, 1'b1, 1'b1);
        repeat (2) step();
        check("parity_err_set", parity_err, 32'd1);
        rx_pop_check("rx_perr");
        pulse_clr();
        check("parity_err_clr", parity_err, 32'd0);
`else
        check("parity_err_tied", parity_err, 32'd0);
`endif

        // Overrun: 17 bytes, no reads
        for (int i = 0; i < 17; i++) begin
            logic [7:0] b;
            b = 8'(i * 37 + 5);
            if (i < 16) rx_exp_q.push_back(b);
            rx_send(b, 1'b1, 1'b0);
            if (i == 15) check("ovr_not_yet", overrun, 32'd0);
        end
        repeat (2) step();
        check("ovr_rx_full", rx_full, 32'd1);
        check("ovr_flag", overrun, 32'd1);
        for (int i = 0; i < 16; i++) rx_pop_check("ovr_pop");
        check("ovr_rx_empty", rx_empty, 32'd1);
        check("ovr_rx_full_clr", rx_full, 32'd0);
        check("ovr_still_set", overrun, 32'd1);
        pulse_clr();
        check("ovr_clr", overrun, 32'd0);

        // Reset during a TX data bit
        tx_write(8'h5A);
        tx_write(8'h77);
        gap = 0;
        while (tx !== 1'b0 && gap < 4 * FRAME_CYC) begin
            step();
            gap++;
        end
        repeat (3 * BIT_CYC) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        tx_exp_q.delete();
        check("rst_mid_tx", tx, 32'd1);
        check("rst_mid_tx_empty", tx_empty, 32'd1);
        repeat (FRAME_CYC) step();
        check("rst_mid_no_resume", tx, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
